divu_arbiter: RTL
=================

# divu_arbiter

Round-robin arbiter and sequencer that shares one multicycle unsigned divider (`divu`) between `N_REQ` requesters. It accepts one request at a time over a valid/ready handshake and latches its operands. It then drives the divider's load strobe, waits the divider's fixed latency, captures the quotient and returns it to the owning requester. Divide-by-zero requests are answered locally without occupying the divider.

## Interface

Parameters:
- `WIDTH`, 8, operand and quotient width; must match the `divu` instance.
- `N_REQ`, 4, number of requesters; 2..8.
- `DIV_LATENCY`, 9, cycles from the end of the divider load cycle until `DIV_QUOTIENT_I` is valid; ≥1.

Ports:
- `CLK_I`  in  1  clock; all logic on rising edge.
- `RST_N_I`  in  1  reset; synchronous, active-low.
- `REQ_VALID_I`  in  N_REQ  per-requester request valid.
- `REQ_READY_O`  out  N_REQ  per-requester accept; at most one bit high.
- `REQ_DIVIDEND_I`  in  N_REQ*WIDTH  packed dividends; requester k at bits [k*WIDTH +: WIDTH].
- `REQ_DIVISOR_I`  in  N_REQ*WIDTH  packed divisors, same packing.
- `RSP_VALID_O`  out  N_REQ  one-hot response strobe, one cycle.
- `RSP_QUOTIENT_O`  out  WIDTH  quotient for the strobed requester.
- `RSP_DZ_O`  out  1  divide-by-zero flag, qualified by `RSP_VALID_O`.
- `BUSY_O`  out  1  high in any state other than IDLE.
- `DIV_LOAD_O`  out  1  to `divu` READY_I; load strobe.
- `DIV_DIVIDEND_O`  out  WIDTH  to `divu` DIVIDEND_I.
- `DIV_DIVISOR_O`  out  WIDTH  to `divu` DIVISOR_I.
- `DIV_QUOTIENT_I`  in  WIDTH  from `divu` QUOTIENT_O.

## Operation

- **States:** IDLE, LOAD, WAIT, RESP.
- **IDLE:**
  - Grant goes to the first requester with `REQ_VALID_I` set, searching from `ptr` upward with wrap to 0.
  - `REQ_READY_O[g]` is driven combinationally high for the winner only. The handshake completes at that edge.
  - At the edge: latch operands into `op_a` and `op_b`, store `g` in `owner`, set `ptr` = (g+1) mod N_REQ.
  - If the latched divisor is 0, go to RESP with `dz`=1 and quotient all-ones. Otherwise go to LOAD.
  - If no request is valid, all `REQ_READY_O` are 0 and the FSM stays in IDLE.
- **LOAD:** `DIV_LOAD_O`=1 for exactly one cycle; load counter `cnt` = DIV_LATENCY-1; go to WAIT.
- **WAIT:**
  - `DIV_LOAD_O`=0; `cnt` decrements each cycle.
  - When `cnt`==0, register `DIV_QUOTIENT_I` into `q_r`, set `dz`=0, go to RESP.
- **RESP:**
  - `RSP_VALID_O[owner]`=1 for one cycle, with `RSP_QUOTIENT_O`=`q_r` and `RSP_DZ_O`=`dz`.
  - Go to IDLE. No requests are accepted in RESP.
  - Responses have no backpressure; requesters must sample the strobe.
- **Divider operands:** `DIV_DIVIDEND_O` and `DIV_DIVISOR_O` are driven from `op_a` and `op_b`. They are stable from LOAD through the end of WAIT.
- **Outside RESP:** `RSP_QUOTIENT_O` and `RSP_DZ_O` are 0.
- **Requester obligations:** a requester keeps `REQ_VALID_I` and its operands stable until it sees its `REQ_READY_O`. Dropping valid before grant is legal; that requester simply isn't granted.
- **Fairness:** each requester waits at most N_REQ-1 other transactions.

## Timing

- **Reset** (`RST_N_I`=0 at an edge):
  - State becomes IDLE; `ptr`, `owner`, `cnt`, `op_a`, `op_b`, `q_r`, `dz` become 0.
  - All outputs are 0 while in reset, including `REQ_READY_O`, which is forced 0 during reset.
- **Reset mid-operation:** any in-flight request is discarded with no response, and the divider load is not reasserted.
- **Latency**, with accept edge = T:
  - LOAD occupies cycle T+1.
  - WAIT occupies T+2 .. T+1+DIV_LATENCY.
  - `RSP_VALID_O` is high in cycle T+2+DIV_LATENCY (11 cycles after accept at the default).
- **Divide-by-zero latency:** `RSP_VALID_O` is high in cycle T+1.
- **Throughput:**
  - Next accept is possible in the cycle after RESP: one transaction per DIV_LATENCY+3 cycles (12 at the default).
  - Divide-by-zero: one per 2 cycles.
- **Simultaneous requests:** exactly one grant per IDLE cycle; the pointer rule decides.
- **Pointer wrap:** a grant to N_REQ-1 sets `ptr`=0.
- **`BUSY_O`:** registered from state; 0 only in IDLE.

## Test plan

- **Reset:** after reset, requester 0 requests 126/13. Accepted in the first IDLE cycle; `DIV_LOAD_O` is high for one cycle at T+1. `RSP_VALID_O`=4'b0001 at T+11 with quotient 9, `RSP_DZ_O`=0.
- **Boundary operands:** requester 2 requests 0x80/0x90 → quotient 0x00. A back-to-back request 0xFF/0x01 → quotient 0xFF. Spacing between accepts is 12 cycles.
- **Round-robin:** all four requesters valid continuously from reset with distinct operands. Grants follow the order 0,1,2,3,0; each response goes to the correct one-hot bit with the correct quotient.
- **Divide-by-zero:** requester 3 requests 0x37/0x00 → `RSP_VALID_O`=4'b1000 at T+1, quotient 0xFF, `RSP_DZ_O`=1, `DIV_LOAD_O` never asserted.
- **Reset mid-operation:** `RST_N_I` pulled low for one cycle during WAIT. No `RSP_VALID_O` follows; FSM is in IDLE with `ptr`=0. A new request from requester 1 then completes normally.
- **Wrap:** only requester 3 and then requester 0 valid. Pointer wraps to 0 after the grant to 3, and requester 0 is granted next.

Source files
------------

// File: rtl/divu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : divu_arbiter_if
// Description : Bundle of the requester handshake, response and divider
//               signals shared by divu_arbiter and its environment.
//               slave  - the arbiter side (accepts requests, drives the
//                        divider and the responses)
//               master - the environment side (requesters plus the divu)
// Signals     : REQ_VALID_I/REQ_READY_O     per-requester handshake
//               REQ_DIVIDEND_I/REQ_DIVISOR_I packed operands, WIDTH each
//               RSP_VALID_O/RSP_QUOTIENT_O/RSP_DZ_O  one-cycle response
//               BUSY_O                        arbiter not idle
//               DIV_LOAD_O/DIV_DIVIDEND_O/DIV_DIVISOR_O/DIV_QUOTIENT_I
//                                             divider connection
// Revision    : 1.0 - initial release
// ============================================================================
interface divu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       REQ_VALID_I;
  logic [N_REQ-1:0]       REQ_READY_O;
  logic [N_REQ*WIDTH-1:0] REQ_DIVIDEND_I;
  logic [N_REQ*WIDTH-1:0] REQ_DIVISOR_I;
  logic [N_REQ-1:0]       RSP_VALID_O;
  logic [WIDTH-1:0]       RSP_QUOTIENT_O;
  logic                   RSP_DZ_O;
  logic                   BUSY_O;
  logic                   DIV_LOAD_O;
  logic [WIDTH-1:0]       DIV_DIVIDEND_O;
  logic [WIDTH-1:0]       DIV_DIVISOR_O;
  logic [WIDTH-1:0]       DIV_QUOTIENT_I;

  modport slave (
    input  REQ_VALID_I, REQ_DIVIDEND_I, REQ_DIVISOR_I, DIV_QUOTIENT_I,
    output REQ_READY_O, RSP_VALID_O, RSP_QUOTIENT_O, RSP_DZ_O, BUSY_O,
           DIV_LOAD_O, DIV_DIVIDEND_O, DIV_DIVISOR_O
  );

  modport master (
    output REQ_VALID_I, REQ_DIVIDEND_I, REQ_DIVISOR_I, DIV_QUOTIENT_I,
    input  REQ_READY_O, RSP_VALID_O, RSP_QUOTIENT_O, RSP_DZ_O, BUSY_O,
           DIV_LOAD_O, DIV_DIVIDEND_O, DIV_DIVISOR_O
  );
endinterface
`default_nettype wire

// File: rtl/divu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : divu_arbiter
// Description : Round-robin arbiter/sequencer sharing one multicycle unsigned
//               divider between N_REQ requesters. One request is accepted at
//               a time, its operands latched, the divider loaded, and after
//               DIV_LATENCY cycles the quotient is returned to the owner as a
//               one-cycle one-hot strobe. Divide-by-zero is answered locally
//               (quotient all-ones, DZ flag) without touching the divider.
// Ports       : CLK_I    clock, rising edge
//               RST_N_I  synchronous active-low reset
//               bus      divu_arbiter_if.slave (handshake, response, divider)
// Revision    : 1.0 - initial release
// ============================================================================
module divu_arbiter #(
  parameter int WIDTH       = 8,
  parameter int N_REQ       = 4,
  parameter int DIV_LATENCY = 9
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  divu_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IDX_W = PTR_W + 1;
  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_q;
  logic               r_dz;
  logic               r_busy;

  logic               w_gnt_found;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [IDX_W-1:0]   w_k;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [N_REQ-1:0]   w_ready;
  logic               w_in_resp;

  // --------------------------------------------------------------------------
  // Round-robin search: start at r_ptr, walk upward with wrap, first valid
  // requester wins. The winner's operands are muxed out here so the accept
  // edge can latch them directly.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_k         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = {1'b0, r_ptr} + IDX_W'(i);
      if (w_k >= IDX_W'(N_REQ)) begin
        w_k = w_k - IDX_W'(N_REQ);
      end
      if (!w_gnt_found && bus.REQ_VALID_I[w_k[PTR_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_k[PTR_W-1:0];
        w_sel_a     = bus.REQ_DIVIDEND_I[int'(w_k[PTR_W-1:0])*WIDTH +: WIDTH];
        w_sel_b     = bus.REQ_DIVISOR_I[int'(w_k[PTR_W-1:0])*WIDTH +: WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and the combinational grant. Ready is forced low in reset so
  // no requester believes a handshake completed on a reset edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_ready     = N_REQ'(1) << w_gnt_idx;
          w_state_nxt = (w_sel_b == '0) ? S_RESP : S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!RST_N_I) begin
      w_ready = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: operand latch, pointer, latency counter, result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_q     <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_owner <= w_gnt_idx;
            r_ptr   <= (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0
                                                        : w_gnt_idx + PTR_W'(1);
            // Divide-by-zero is resolved here and skips the divider entirely.
            if (w_sel_b == '0) begin
              r_q  <= '1;
              r_dz <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_cnt <= CNT_W'(DIV_LATENCY - 1);
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_q  <= bus.DIV_QUOTIENT_I;
            r_dz <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all held at zero while reset is asserted
  // --------------------------------------------------------------------------
  assign w_in_resp          = (r_state == S_RESP) && RST_N_I;

  assign bus.REQ_READY_O    = w_ready;
  assign bus.RSP_VALID_O    = w_in_resp ? (N_REQ'(1) << r_owner) : '0;
  assign bus.RSP_QUOTIENT_O = w_in_resp ? r_q : '0;
  assign bus.RSP_DZ_O       = w_in_resp & r_dz;
  assign bus.BUSY_O         = r_busy & RST_N_I;
  assign bus.DIV_LOAD_O     = (r_state == S_LOAD) && RST_N_I;
  assign bus.DIV_DIVIDEND_O = RST_N_I ? r_op_a : '0;
  assign bus.DIV_DIVISOR_O  = RST_N_I ? r_op_b : '0;

endmodule
`default_nettype wire
